// File: rtl/chain_sched_if.sv
// Opcode package and host/chain/result bus bundle for chain_sched.
// slave is the scheduler's view; master is the host/chain environment.
package chain_sched_pkg;
   typedef enum logic [2:0] {
      DEL = 3'd0,
      SET = 3'd1,
      ADD = 3'd2,
      RDC = 3'd3,
      MSC = 3'd4
   } opcode_t;
endpackage

interface chain_sched_if;
   import chain_sched_pkg::*;

   logic        cmd_valid;
   logic        cmd_ready;
   opcode_t     cmd_opc;
   logic        cmd_mode;
   logic [27:0] cmd_id;

   logic        bgn_out;
   logic        fns_in;
   opcode_t     opc_out;
   logic        mode_out;
   logic [27:0] id_out;

   logic        bgn_in;
   logic        fns_out;
   opcode_t     opc_in;
   logic        mode_in;
   logic [27:0] id_in;

   logic        res_valid;
   logic        res_ready;
   opcode_t     res_opc;
   logic        res_mode;
   logic [27:0] res_id;

   modport slave (
      input  cmd_valid, cmd_opc, cmd_mode, cmd_id,
      output cmd_ready,
      output bgn_out, opc_out, mode_out, id_out,
      input  fns_in,
      input  bgn_in, opc_in, mode_in, id_in,
      output fns_out,
      output res_valid, res_opc, res_mode, res_id,
      input  res_ready
   );

   modport master (
      output cmd_valid, cmd_opc, cmd_mode, cmd_id,
      input  cmd_ready,
      input  bgn_out, opc_out, mode_out, id_out,
      output fns_in,
      output bgn_in, opc_in, mode_in, id_in,
      input  fns_out,
      input  res_valid, res_opc, res_mode, res_id,
      output res_ready
   );
endinterface

// File: rtl/chain_sched.sv
// Chain scheduler: issues host tokens to a chain head, collects tail tokens.
// Optional statistics counters enabled by CHAIN_SCHED_STATS_EN.
module chain_sched
   import chain_sched_pkg::*;
#(
   parameter int RES_DEPTH = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   chain_sched_if.slave bus,
   output logic        sync_done,
   output logic        conflict,
   output logic        err,
   input  logic        clr,
   output logic [31:0] stat_issued,
   output logic [31:0] stat_tail,
   output logic [31:0] stat_conf
);
   localparam int AW = $clog2(RES_DEPTH);
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE, S_SEND, S_SYNC, S_ERROR
   } state_t;

   state_t        state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          sync_nx, err_nx;

   logic          cmd_fire, head_ack;
   logic          barrier_out, barrier_in;
   logic          cap, push, pop, conf_hit;
   logic [AW:0]   wp, rp, cnt;
   logic          full;

   opcode_t     mem_opc  [RES_DEPTH];
   logic        mem_mode [RES_DEPTH];
   logic [27:0] mem_id   [RES_DEPTH];

   assign bus.cmd_ready = (state == S_IDLE) && !bus.bgn_out;
   assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
   assign head_ack  = (state == S_SEND) && bus.fns_in;

   assign barrier_out = (bus.opc_out == MSC) && (bus.id_out == 28'd1);
   assign barrier_in  = (bus.opc_in == MSC) && (bus.id_in == 28'd1);

   assign cnt  = wp - rp;
   assign full = (cnt == (AW+1)'(RES_DEPTH));
   // Capture needs fns_out low last cycle so each token gets a single pulse
   assign cap      = bus.bgn_in && !full && !bus.fns_out;
   assign push     = cap && !barrier_in;
   assign pop      = bus.res_valid && bus.res_ready;
   assign conf_hit = cap && (bus.opc_in == RDC) && !bus.mode_in;

   assign bus.res_valid = (cnt != '0);
   assign bus.res_opc   = mem_opc[rp[AW-1:0]];
   assign bus.res_mode  = mem_mode[rp[AW-1:0]];
   assign bus.res_id    = mem_id[rp[AW-1:0]];

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      sync_nx  = 1'b0;
      err_nx   = err;
      case (state)
         S_IDLE: begin
            if (cmd_fire) state_nx = S_SEND;
         end
         S_SEND: begin
            if (bus.fns_in) begin
               if (barrier_out) begin
                  state_nx = S_SYNC;
                  timer_nx = '0;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_SYNC: begin
            if (cap && barrier_in) begin
               sync_nx  = 1'b1;
               state_nx = S_IDLE;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               err_nx   = 1'b1;
               state_nx = S_ERROR;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         S_ERROR: begin
            if (clr) begin
               err_nx   = 1'b0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         timer     <= '0;
         sync_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         sync_done <= sync_nx;
         err       <= err_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bgn_out  <= 1'b0;
         bus.opc_out  <= DEL;
         bus.mode_out <= 1'b0;
         bus.id_out   <= '0;
      end else if (cmd_fire) begin
         bus.bgn_out  <= 1'b1;
         bus.opc_out  <= bus.cmd_opc;
         bus.mode_out <= bus.cmd_mode;
         bus.id_out   <= bus.cmd_id;
      end else if (head_ack) begin
         bus.bgn_out  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.fns_out <= 1'b0;
         conflict    <= 1'b0;
         wp          <= '0;
         rp          <= '0;
         for (int i = 0; i < RES_DEPTH; i++) begin
            mem_opc[i]  <= DEL;
            mem_mode[i] <= 1'b0;
            mem_id[i]   <= '0;
         end
      end else begin
         bus.fns_out <= cap;
         if (conf_hit)  conflict <= 1'b1;
         else if (clr)  conflict <= 1'b0;
         if (push) begin
            mem_opc[wp[AW-1:0]]  <= bus.opc_in;
            mem_mode[wp[AW-1:0]] <= bus.mode_in;
            mem_id[wp[AW-1:0]]   <= bus.id_in;
            wp <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
      end
   end

`ifdef CHAIN_SCHED_STATS_EN
   logic [31:0] n_iss, n_tail, n_conf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_iss  <= '0;
         n_tail <= '0;
         n_conf <= '0;
      end else if (clr) begin
         n_iss  <= '0;
         n_tail <= '0;
         n_conf <= '0;
      end else begin
         if (head_ack && n_iss != '1)  n_iss  <= n_iss + 1'b1;
         if (cap && n_tail != '1)      n_tail <= n_tail + 1'b1;
         if (conf_hit && n_conf != '1) n_conf <= n_conf + 1'b1;
      end
   end

   assign stat_issued = n_iss;
   assign stat_tail   = n_tail;
   assign stat_conf   = n_conf;
`else
   assign stat_issued = '0;
   assign stat_tail   = '0;
   assign stat_conf   = '0;
`endif
endmodule

// File: tb/tb_chain_sched.sv
// Scoreboard bench for chain_sched: random head/tail traffic against a
// token-level model; result tokens are checked by a separate monitor.
module tb_chain_sched;
   import chain_sched_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        sync_done;
   logic        conflict;
   logic        err;
   logic [31:0] stat_issued;
   logic [31:0] stat_tail;
   logic [31:0] stat_conf;

   chain_sched_if bus();

   chain_sched #(.RES_DEPTH(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .sync_done   (sync_done),
      .conflict    (conflict),
      .err         (err),
      .clr         (clr),
      .stat_issued (stat_issued),
      .stat_tail   (stat_tail),
      .stat_conf   (stat_conf)
   );

   typedef struct {
      opcode_t     opc;
      logic        mode;
      logic [27:0] id;
   } tok_t;

   int     tests = 0;
   int     fails = 0;
   tok_t   exp_q[$];
   int     sync_cnt = 0;
   int     rr_mode = 0;
   longint iss_m, tail_m, conf_m;
   logic   conf_exp;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   task automatic chk(input string n, input longint a, input longint e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", n, a, e);
      end
   endtask

   always @(posedge clk) begin
      #2;
      case (rr_mode)
         0:       bus.res_ready = 1'b0;
         1:       bus.res_ready = 1'b1;
         default: bus.res_ready = 1'($urandom % 2);
      endcase
   end

   always @(negedge clk) begin
      if (sync_done) sync_cnt++;
   end

   tok_t mt;
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL res_extra: got id %0d, want no token", bus.res_id);
         end else begin
            mt = exp_q.pop_front();
            chk("res_tok", {bus.res_opc, bus.res_mode, bus.res_id},
                {mt.opc, mt.mode, mt.id});
         end
      end
   end

   task automatic chk_stats(input string n);
`ifdef CHAIN_SCHED_STATS_EN
      chk({n, "_issued"}, stat_issued, iss_m);
      chk({n, "_tail"}, stat_tail, tail_m);
      chk({n, "_conf"}, stat_conf, conf_m);
`else
      chk({n, "_issued"}, stat_issued, 0);
      chk({n, "_tail"}, stat_tail, 0);
      chk({n, "_conf"}, stat_conf, 0);
`endif
   endtask

   task automatic model_zero();
      iss_m    = 0;
      tail_m   = 0;
      conf_m   = 0;
      conf_exp = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_zero();
   endtask

   task automatic send_cmd(input opcode_t o, input logic m,
                           input logic [27:0] i, input int lat);
      int  w;
      int  hi;
      logic stable;
      w = 0;
      while (!bus.cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_wait", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_opc   = o;
      bus.cmd_mode  = m;
      bus.cmd_id    = i;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      hi = 0;
      stable = 1'b1;
      for (int k = 0; k < lat; k++) begin
         if (bus.bgn_out) hi++;
         if (bus.opc_out != o || bus.mode_out != m || bus.id_out != i)
            stable = 1'b0;
         if (k == lat - 1) bus.fns_in = 1'b1;
         @(negedge clk);
      end
      bus.fns_in = 1'b0;
      iss_m++;
      chk("bgn_hi", hi, lat);
      chk("head_payload", stable, 1);
      chk("bgn_drop", bus.bgn_out, 0);
      chk("ready_after", bus.cmd_ready, (o == MSC && i == 28'd1) ? 0 : 1);
   endtask

   task automatic tail_send(input opcode_t o, input logic m,
                            input logic [27:0] i);
      int   w;
      tok_t t;
      w = 0;
      t.opc = o;
      t.mode = m;
      t.id = i;
      if (!(o == MSC && i == 28'd1)) exp_q.push_back(t);
      bus.bgn_in  = 1'b1;
      bus.opc_in  = o;
      bus.mode_in = m;
      bus.id_in   = i;
      @(negedge clk);
      while (!bus.fns_out && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("tail_wait", bus.fns_out, 1);
      if (bus.fns_out) begin
         tail_m++;
         if (o == RDC && !m) begin
            conf_m++;
            conf_exp = 1'b1;
         end
      end
      bus.bgn_in = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      rr_mode = 1;
      while (bus.res_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      rr_mode = 0;
      repeat (2) @(negedge clk);
      chk("drain_empty", bus.res_valid, 0);
   endtask

   function automatic tok_t rnd_tok(input logic no_barrier);
      tok_t t;
      t.opc  = opcode_t'($urandom_range(0, 4));
      t.mode = 1'($urandom % 2);
      t.id   = 28'($urandom);
      if (no_barrier && t.opc == MSC && t.id == 28'd1) t.id = 28'd2;
      return t;
   endfunction

   initial begin
      int   base;
      tok_t t;
      rst_n = 1'b0;
      clr = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_opc   = DEL;
      bus.cmd_mode  = 1'b0;
      bus.cmd_id    = '0;
      bus.fns_in    = 1'b0;
      bus.bgn_in    = 1'b0;
      bus.opc_in    = DEL;
      bus.mode_in   = 1'b0;
      bus.id_in     = '0;
      bus.res_ready = 1'b0;
      model_zero();
      repeat (3) @(negedge clk);

      chk("rst_bgn_out", bus.bgn_out, 0);
      chk("rst_fns_out", bus.fns_out, 0);
      chk("rst_sync", sync_done, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_err", err, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_opc_out", bus.opc_out, DEL);
      chk("rst_mode_out", bus.mode_out, 0);
      chk("rst_id_out", bus.id_out, 0);
      chk_stats("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", bus.cmd_ready, 1);

      send_cmd(ADD, 1'b1, 28'd5, 3);
      for (int k = 0; k < 8; k++) begin
         t = rnd_tok(1'b1);
         send_cmd(t.opc, t.mode, t.id, int'($urandom_range(1, 4)));
      end

      send_cmd(MSC, 1'b0, 28'd1, 2);
      repeat (10) @(negedge clk);
      base = sync_cnt;
      tail_send(MSC, 1'b0, 28'd1);
      repeat (3) @(negedge clk);
      chk("sync_pulses", sync_cnt - base, 1);
      chk("sync_ready", bus.cmd_ready, 1);
      chk("sync_no_push", bus.res_valid, 0);

      send_cmd(MSC, 1'b1, 28'd1, 1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 15) chk("err_early", err, 0);
         if (k == 16) chk("err_set", err, 1);
      end
      repeat (3) @(negedge clk);
      chk("err_ready", bus.cmd_ready, 0);
      tail_send(SET, 1'b1, 28'd77);
      chk("err_tail_push", bus.res_valid, 1);
      chk("err_hold", err, 1);
      chk_stats("pre_clr");
      do_clr();
      chk("clr_err", err, 0);
      chk("clr_ready", bus.cmd_ready, 1);
      chk_stats("post_clr");
      drain();

      tail_send(RDC, 1'b0, 28'd9);
      chk("conflict_set", conflict, 1);
      chk("conf_valid", bus.res_valid, 1);
      chk("conf_opc", bus.res_opc, RDC);
      chk("conf_mode", bus.res_mode, 0);
      chk("conf_id", bus.res_id, 9);
      chk_stats("conf");
      drain();
      do_clr();
      chk("conflict_clr", conflict, 0);

      t.opc = RDC;
      t.mode = 1'b0;
      t.id = 28'd5;
      exp_q.push_back(t);
      bus.bgn_in  = 1'b1;
      bus.opc_in  = RDC;
      bus.mode_in = 1'b0;
      bus.id_in   = 28'd5;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      bus.bgn_in = 1'b0;
      chk("setclr_cap", bus.fns_out, 1);
      chk("setclr_conflict", conflict, 1);
      iss_m = 0;
      tail_m = 0;
      conf_m = 0;
      chk_stats("setclr");
      drain();
      do_clr();

      fork
         begin
            for (int k = 0; k < 6; k++) tail_send(RDC, 1'b1, 28'(100 + k));
         end
         begin
            repeat (40) @(negedge clk);
            chk("full_caps", tail_m, 4);
            chk("full_fns_low", bus.fns_out, 0);
            chk("full_valid", bus.res_valid, 1);
            rr_mode = 1;
            @(negedge clk);
            rr_mode = 0;
            @(negedge clk);
            chk("pop_cycle_nocap", bus.fns_out, 0);
            @(negedge clk);
            chk("cap_after_pop", bus.fns_out, 1);
            repeat (2) @(negedge clk);
            rr_mode = 1;
         end
      join
      drain();
      chk_stats("full");

      base = sync_cnt;
      rr_mode = 2;
      fork
         begin
            tok_t h;
            for (int k = 0; k < 12; k++) begin
               h = rnd_tok(1'b1);
               send_cmd(h.opc, h.mode, h.id, int'($urandom_range(1, 4)));
            end
         end
         begin
            tok_t r;
            for (int k = 0; k < 30; k++) begin
               if ($urandom % 8 == 0) begin
                  tail_send(MSC, 1'($urandom % 2), 28'd1);
               end else begin
                  r = rnd_tok(1'b0);
                  tail_send(r.opc, r.mode, r.id);
               end
               if ($urandom % 3 == 0) @(negedge clk);
            end
         end
      join
      drain();
      chk("rand_left", exp_q.size(), 0);
      chk("rand_conflict", conflict, conf_exp);
      chk("rand_no_sync", sync_cnt - base, 0);
      chk_stats("rand");

      bus.cmd_valid = 1'b1;
      bus.cmd_opc   = ADD;
      bus.cmd_mode  = 1'b0;
      bus.cmd_id    = 28'd42;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("mid_bgn", bus.bgn_out, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_drop_bgn", bus.bgn_out, 0);
      chk("rst_drop_opc", bus.opc_out, DEL);
      chk("rst_drop_id", bus.id_out, 0);
      chk("rst_drop_conf", conflict, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_zero();
      repeat (3) @(negedge clk);
      chk("no_reissue", bus.bgn_out, 0);
      chk("rst_ready", bus.cmd_ready, 1);
      chk_stats("rst2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/chain_sched.md
CHAIN_SCHED -- requirements
Module: chain_sched

Interface
REQ-001 Parameter RES_DEPTH, default 4: result FIFO depth (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 1024: max cycles spent in SYNC before error.
REQ-003 clk  input  1  sole clock, all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  host command handshake; transfer when both high.
REQ-006 cmd_opc/cmd_mode/cmd_id  input  opcode/1/28  host command token (pkg opcode: DEL, SET, ADD, RDC, MSC).
REQ-007 bgn_out/fns_in  out/in  1/1  chain-head token handshake.
REQ-008 opc_out/mode_out/id_out  output  opcode/1/28  chain-head token payload.
REQ-009 bgn_in/fns_out  in/out  1/1  chain-tail token handshake.
REQ-010 opc_in/mode_in/id_in  input  opcode/1/28  chain-tail token payload.
REQ-011 res_valid/res_ready  out/in  1/1  result FIFO to host.
REQ-012 res_opc/res_mode/res_id  output  opcode/1/28  result FIFO head token.
REQ-013 sync_done  output  1  one-cycle pulse on barrier completion.
REQ-014 conflict/err/clr  out/out/in  1/1/1  sticky conflict, sticky timeout error, clear pulse.
REQ-015 stat_issued/stat_tail/stat_conf  output  32 each  statistics counters.

Function
REQ-016 FSM states IDLE, SEND, SYNC, ERROR; cmd_ready = (state==IDLE) and !bgn_out.
REQ-017 IDLE: on a cmd transfer, register payload onto opc/mode/id_out, assert bgn_out next cycle, go to SEND.
REQ-018 SEND: bgn_out and payload held stable until fns_in high; bgn_out low the cycle after fns_in is sampled high.
REQ-019 SEND exit: if the sent token is MSC with id 1 (UNF, barrier), go to SYNC and clear timer; otherwise go to IDLE.
REQ-020 SYNC: tail MSC/id 1 token consumed -> pulse sync_done, go to IDLE; timer reaching TIMEOUT-1 -> set err, go to ERROR.
REQ-021 ERROR: cmd_ready low; clr pulse clears err and returns to IDLE; tail handling continues.
REQ-022 Tail: fns_out pulses exactly one cycle when bgn_in high, FIFO not full, and fns_out was low the previous cycle; payload captured in the same cycle.
REQ-023 Captured MSC/id 1 tokens are not pushed; all other captured tokens are pushed to the result FIFO.
REQ-024 FIFO full: fns_out held low and bgn_in left pending; simultaneous push and pop on a non-full FIFO leaves the count unchanged.
REQ-025 FIFO full with res_ready high: pop that cycle; push allowed from the following cycle.
REQ-026 res_valid = FIFO non-empty; res_* show the head token with zero added latency.
REQ-027 Captured RDC with mode 0 sets conflict; clr clears it; a set in the same cycle as clr wins.
REQ-028 Head and tail handshakes run independently; tokens arriving at the tail in IDLE or SEND are handled identically.

Reset
REQ-029 rst_n low: state IDLE; bgn_out, fns_out, sync_done, conflict, err, res_valid all 0; opc_out DEL, mode_out 0, id_out 0; FIFO empty; timer and stat counters 0.
REQ-030 Reset mid-handshake drops bgn_out immediately; the in-flight token is discarded, not re-issued.

Configuration
REQ-031 Macro CHAIN_SCHED_STATS_EN defined: stat_issued counts fns_in acceptances, stat_tail counts fns_out pulses, stat_conf counts RDC mode-0 captures; all saturate at 2^32-1 and are cleared by clr.
REQ-032 CHAIN_SCHED_STATS_EN undefined: counters absent, stat_* tied to 0, ports unchanged.

Verification
REQ-033 ADD id 5 mode 1 command; fns_in 3 cycles later -> bgn_out high 3 cycles, low the next cycle; payload stable; state IDLE.
REQ-034 MSC id 1 issued; tail returns MSC id 1 after 10 cycles -> sync_done pulses once; FIFO stays empty.
REQ-035 MSC id 1 issued, no tail token, TIMEOUT=16 -> err=1 after 16 SYNC cycles; cmd_ready 0 until clr.
REQ-036 RES_DEPTH=4, res_ready 0, 6 tail RDC tokens -> 4 captured, fns_out low; one pop -> 5th captured the next cycle.
REQ-037 Tail RDC mode 0 id 9 -> conflict=1; res_* = RDC/0/9; stat_conf=1 with the macro defined, 0 without.
